hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined MIPS core. It replaces fixed-stage hazard detection and forwarding logic with a DEPTH-slot scoreboard of in-flight destination registers. Each cycle it decides whether the instruction in ID must stall and, per source operand, which pipeline slot supplies its forwarded value. It keeps the core's `forwarding` and `stalling` mode switches and adds saturating stall and forward performance counters.

---
 rtl/hazard_scoreboard.sv | 108 ++++++++++
 tb/tb_hazard_scoreboard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard and forwarding controller: tracks DEPTH in-flight destinations
// after ID, decides stalls and per-operand forward selects, and counts stalls/forwards.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              forwarding,
    input  logic              stalling,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rs,
    input  logic [REG_AW-1:0] issue_rt,
    input  logic              issue_uses_rs,
    input  logic              issue_uses_rt,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_reg_write,
    input  logic              issue_is_load,
    input  logic              flush,
    output logic              stall_out,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  fwd_count
);

    typedef struct packed {
        logic             haz;
        logic [SEL_W-1:0] sel;
    } src_res_t;

    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  ld_q;
    logic [REG_AW-1:0] dst_q [DEPTH];
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  fwd_cnt_q, fwd_cnt_d;
    logic              slot0_vld_d;
    src_res_t          rs_res, rt_res;

    // Walk oldest to youngest so the youngest match is the one left standing.
    function automatic src_res_t resolve(input logic [REG_AW-1:0] s, input logic used);
        src_res_t r;
        logic     hit;
        logic     rdy;
        int       pos;
        r   = '0;
        hit = 1'b0;
        rdy = 1'b0;
        pos = 0;
        for (int p = DEPTH - 1; p >= 0; p--) begin
            if (used && (s != '0) && vld_q[p] && (dst_q[p] == s)) begin
                hit = 1'b1;
                pos = p;
                rdy = ld_q[p] ? (p >= LOAD_LAT) : 1'b1;
            end
        end
        if (hit) begin
            if (!forwarding || !rdy) r.haz = 1'b1;
            else                     r.sel = SEL_W'(pos + 1);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        rs_res      = resolve(issue_rs, issue_uses_rs);
        rt_res      = resolve(issue_rt, issue_uses_rt);
        fwd_rs_sel  = rs_res.sel;
        fwd_rt_sel  = rt_res.sel;
        stall_out   = stalling & issue_valid & ~flush & (rs_res.haz | rt_res.haz);
        slot0_vld_d = issue_valid & issue_reg_write & (issue_rd != '0) & ~stall_out & ~flush;
        stall_cnt_d = stall_out ? sat_inc(stall_cnt_q) : stall_cnt_q;
        fwd_cnt_d   = ((|fwd_rs_sel) | (|fwd_rt_sel)) ? sat_inc(fwd_cnt_q) : fwd_cnt_q;
    end

    // Valid bits and counters carry reset; slot payload only matters when valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q       <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            for (int p = DEPTH - 1; p >= 1; p--) vld_q[p] <= vld_q[p-1];
            vld_q[0]    <= slot0_vld_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = DEPTH - 1; p >= 1; p--) begin
            dst_q[p] <= dst_q[p-1];
            ld_q[p]  <= ld_q[p-1];
        end
        dst_q[0] <= issue_rd;
        ld_q[0]  <= issue_is_load;
    end

    assign stall_count = stall_cnt_q;
    assign fwd_count   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a timestamped producer-list model.
module tb_hazard_scoreboard;
    localparam int REG_AW = 5, DEPTH = 3, LOAD_LAT = 1, CNT_W = 4, SEL_W = 2;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk, rst, forwarding, stalling, issue_valid, issue_uses_rs, issue_uses_rt;
    logic issue_reg_write, issue_is_load, flush, stall_out;
    logic [REG_AW-1:0] issue_rs, issue_rt, issue_rd;
    logic [SEL_W-1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [CNT_W-1:0]  stall_count, fwd_count;

    hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT),
                        .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .forwarding(forwarding), .stalling(stalling),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt),
        .issue_rd(issue_rd), .issue_reg_write(issue_reg_write),
        .issue_is_load(issue_is_load), .flush(flush), .stall_out(stall_out),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .stall_count(stall_count), .fwd_count(fwd_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: producers that entered the pipeline, stamped with the cycle they issued.
    typedef struct { logic [REG_AW-1:0] rd; bit ld; int cyc; } prod_t;
    prod_t prod[$];
    int cnow = 0;
    int e_scnt = 0, e_fcnt = 0;
    bit e_stall;
    int e_rs, e_rt;
    int vectors = 0, miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // A value issued at cycle c is forwardable from slot (age-1) once that reaches its
    // readiness index, and is in the register file after DEPTH cycles.
    task automatic src(input logic [REG_AW-1:0] s, input bit used, output bit haz, output int sel);
        int best, bage;
        bit bld;
        haz = 0; sel = 0; best = -1; bage = 0; bld = 0;
        foreach (prod[i]) begin
            int age;
            age = cnow - prod[i].cyc;
            if (used && s != 0 && prod[i].rd == s && age >= 1 && age <= DEPTH && prod[i].cyc > best) begin
                best = prod[i].cyc; bage = age; bld = prod[i].ld;
            end
        end
        if (best >= 0) begin
            if (!forwarding) haz = 1;
            else if (bage - 1 >= (bld ? LOAD_LAT : 0)) sel = bage;
            else haz = 1;
        end
    endtask

    task automatic model_eval();
        bit hs, ht;
        src(issue_rs, issue_uses_rs, hs, e_rs);
        src(issue_rt, issue_uses_rt, ht, e_rt);
        e_stall = stalling && issue_valid && !flush && (hs || ht);
    endtask

    task automatic compare_all();
        model_eval();
        chk("stall_out", 32'(stall_out), 32'(e_stall));
        chk("fwd_rs_sel", 32'(fwd_rs_sel), e_rs);
        chk("fwd_rt_sel", 32'(fwd_rt_sel), e_rt);
        chk("stall_count", 32'(stall_count), e_scnt);
        chk("fwd_count", 32'(fwd_count), e_fcnt);
    endtask

    task automatic apply(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input int rd, input bit rw, input bit ld, input bit fl);
        issue_valid = v; issue_rs = REG_AW'(rs); issue_rt = REG_AW'(rt);
        issue_uses_rs = urs; issue_uses_rt = urt; issue_rd = REG_AW'(rd);
        issue_reg_write = rw; issue_is_load = ld; flush = fl;
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic advance();
        @(posedge clk);
        model_eval();
        if (e_stall && e_scnt < CMAX) e_scnt++;
        if ((e_rs != 0 || e_rt != 0) && e_fcnt < CMAX) e_fcnt++;
        if (issue_valid && issue_reg_write && issue_rd != 0 && !e_stall && !flush)
            prod.push_back('{rd: issue_rd, ld: issue_is_load, cyc: cnow});
        cnow++;
        while (prod.size() > 0 && cnow - prod[0].cyc > DEPTH) void'(prod.pop_front());
        #1;
    endtask

    task automatic model_clear();
        prod.delete(); e_scnt = 0; e_fcnt = 0;
    endtask

    task automatic check_reset_state();
        chk("rst stall_out", 32'(stall_out), 0);
        chk("rst fwd_rs_sel", 32'(fwd_rs_sel), 0);
        chk("rst fwd_rt_sel", 32'(fwd_rt_sel), 0);
        chk("rst stall_count", 32'(stall_count), 0);
        chk("rst fwd_count", 32'(fwd_count), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        issue_valid = 0; issue_uses_rs = 0; issue_uses_rt = 0; issue_reg_write = 0;
        issue_is_load = 0; flush = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0;
        #1;
        check_reset_state();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bit st;
        rst = 1'b0; forwarding = 1; stalling = 1;
        issue_valid = 0; issue_uses_rs = 0; issue_uses_rt = 0; issue_reg_write = 0;
        issue_is_load = 0; flush = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0;
        @(posedge clk); #1;
        do_reset();

        // ALU back-to-back forward
        apply(1, 0, 0, 0, 0, 3, 1, 0, 0); advance();
        apply(1, 3, 5, 1, 1, 4, 1, 0, 0);
        chk("alu stall", 32'(stall_out), 0);
        chk("alu rs_sel", 32'(fwd_rs_sel), 1);
        chk("alu rt_sel", 32'(fwd_rt_sel), 0);
        advance(); idle();
        chk("alu fwd_count", 32'(fwd_count), 1);
        advance();

        // Load-use stall
        do_reset();
        apply(1, 0, 0, 0, 0, 2, 1, 1, 0); advance();
        apply(1, 2, 2, 1, 1, 6, 1, 0, 0);
        chk("lu stall", 32'(stall_out), 1);
        chk("lu rs_sel0", 32'(fwd_rs_sel), 0);
        advance();
        apply(1, 2, 2, 1, 1, 6, 1, 0, 0);
        chk("lu stall2", 32'(stall_out), 0);
        chk("lu rs_sel", 32'(fwd_rs_sel), 2);
        chk("lu rt_sel", 32'(fwd_rt_sel), 2);
        advance(); idle();
        chk("lu stall_count", 32'(stall_count), 1);
        advance();

        // No-forwarding mode
        do_reset();
        forwarding = 0;
        apply(1, 0, 0, 0, 0, 3, 1, 0, 0); advance();
        for (int i = 0; i < DEPTH; i++) begin
            apply(1, 3, 0, 1, 1, 7, 1, 0, 0);
            chk("nofwd stall", 32'(stall_out), 1);
            advance();
        end
        apply(1, 3, 0, 1, 1, 7, 1, 0, 0);
        chk("nofwd release", 32'(stall_out), 0);
        chk("nofwd rs_sel", 32'(fwd_rs_sel), 0);
        advance(); idle();
        chk("nofwd stall_count", 32'(stall_count), DEPTH);
        advance();
        forwarding = 1;

        // Stalling disabled, then register 0
        do_reset();
        stalling = 0;
        apply(1, 0, 0, 0, 0, 2, 1, 1, 0); advance();
        apply(1, 2, 2, 1, 1, 6, 1, 0, 0);
        chk("nostall stall", 32'(stall_out), 0);
        advance();
        stalling = 1;
        apply(1, 0, 0, 0, 0, 0, 1, 0, 0); advance();
        apply(1, 0, 0, 1, 1, 8, 1, 0, 0);
        chk("r0 stall", 32'(stall_out), 0);
        chk("r0 rs_sel", 32'(fwd_rs_sel), 0);
        chk("r0 rt_sel", 32'(fwd_rt_sel), 0);
        advance();

        // Flush priority
        do_reset();
        apply(1, 0, 0, 0, 0, 2, 1, 1, 0); advance();
        apply(1, 2, 2, 1, 1, 9, 1, 0, 1);
        chk("flush stall", 32'(stall_out), 0);
        advance();
        apply(1, 9, 9, 1, 1, 10, 1, 0, 0);
        chk("flush reader stall", 32'(stall_out), 0);
        chk("flush reader sel", 32'(fwd_rs_sel), 0);
        advance();

        // Saturation, then asynchronous reset mid-stall
        do_reset();
        forwarding = 0;
        for (int n = 0; n < 7; n++) begin
            apply(1, 0, 0, 0, 0, 3, 1, 0, 0); advance();
            for (int k = 0; k < 10; k++) begin
                apply(1, 3, 3, 1, 1, 4, 1, 0, 0);
                st = e_stall;
                advance();
                if (!st) break;
            end
        end
        idle();
        chk("sat stall_count", 32'(stall_count), CMAX);
        advance();
        apply(1, 0, 0, 0, 0, 3, 1, 0, 0); advance();
        apply(1, 3, 3, 1, 1, 4, 1, 0, 0);
        chk("midstall stall", 32'(stall_out), 1);
        #1 rst = 1'b0;
        #1;
        check_reset_state();
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        forwarding = 1;

        // Randomized traffic
        for (int c = 0; c < 900; c++) begin
            if (c % 150 == 149) do_reset();
            forwarding = ($urandom_range(0, 7) != 0);
            stalling   = ($urandom_range(0, 9) != 0);
            apply($urandom_range(0, 5) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0);
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
